// File: rtl/qspi_psram_model_p.sv
// qspi_psram_model_p
// Cycle-accurate bench-side model of a quad-SPI PSRAM, oversampled by clk.
// Supports serial read/write (0x03/0x02), quad read/write (0xEB/0x38),
// QPI enter/exit (0x35/0xF5) and reset-enable/reset (0x66/0x99).
// Ports:
//   clk      oversampling clock
//   rst      asynchronous active-high reset
//   sck      serial clock from controller (idle low)
//   ce_n     chip enable, active low
//   sio_i    serial I/O input lines
//   sio_o    serial I/O output data
//   sio_oe   per-line output enable
//   qpi_mode 1 while QPI mode is active
//   cmd_err  one-clk pulse on an unsupported opcode
module qspi_psram_model_p #(
    parameter int MEM_ABITS = 16,
    parameter int RD_WAIT   = 6,
    parameter int PAGE_BITS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sck,
    input  logic       ce_n,
    input  logic [3:0] sio_i,
    output logic [3:0] sio_o,
    output logic [3:0] sio_oe,
    output logic       qpi_mode,
    output logic       cmd_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADR, S_WAIT, S_RDAT, S_WDAT, S_ERR
    } state_t;

    localparam logic [MEM_ABITS-1:0] PAGE_MASK =
        MEM_ABITS'((64'd1 << PAGE_BITS) - 64'd1);

    state_t                 r_state;
    logic                   r_sck, r_sck_q, r_ce_n;
    logic                   r_start_ok;  // ce_n seen high since reset
    logic                   r_armed;
    logic                   r_ser;       // address/data phase uses one line
    logic                   r_rd;
    logic [7:0]             r_cnt;
    logic [23:0]            r_sh;
    logic [MEM_ABITS-1:0]   r_ptr;
    logic [7:0]             r_mem [0:(1<<MEM_ABITS)-1];

    logic                   w_rise, w_fall, w_unit_ser, w_done, w_we, w_rbit;
    logic [23:0]            w_sh_next;
    logic [7:0]             w_last, w_op, w_rbyte;
    logic [MEM_ABITS-1:0]   w_ptr_inc;
    logic                   w_op_rd, w_op_wr, w_op_ctl, w_op_bad;

    assign w_rise     = r_sck & ~r_sck_q;
    assign w_fall     = ~r_sck & r_sck_q;
    // Command width follows the mode; later phases follow the opcode.
    assign w_unit_ser = (r_state == S_CMD) ? ~qpi_mode : r_ser;
    assign w_sh_next  = w_unit_ser ? {r_sh[22:0], sio_i[0]} : {r_sh[19:0], sio_i};
    assign w_done     = (r_cnt == w_last);

    // Units per phase, minus one
    always_comb begin
        w_last = 8'd0;
        case (r_state)
            S_CMD:          w_last = qpi_mode ? 8'd1 : 8'd7;
            S_ADR:          w_last = r_ser ? 8'd23 : 8'd5;
            S_WAIT:         w_last = 8'(RD_WAIT - 1);
            S_RDAT, S_WDAT: w_last = r_ser ? 8'd7 : 8'd1;
            default:        w_last = 8'd0;
        endcase
    end

    // Opcode decode; serial opcodes are only legal outside QPI
    assign w_op     = w_sh_next[7:0];
    assign w_op_rd  = (w_op == 8'hEB) || (w_op == 8'h03 && !qpi_mode);
    assign w_op_wr  = (w_op == 8'h38) || (w_op == 8'h02 && !qpi_mode);
    assign w_op_ctl = (w_op == 8'h35) || (w_op == 8'hF5) ||
                      (w_op == 8'h66) || (w_op == 8'h99);
    assign w_op_bad = !(w_op_rd || w_op_wr || w_op_ctl);

    // Low page bits wrap, upper bits hold
    assign w_ptr_inc = (r_ptr & ~PAGE_MASK) | ((r_ptr + MEM_ABITS'(1)) & PAGE_MASK);

    assign w_rbyte = r_mem[r_ptr];
    assign w_rbit  = w_rbyte[3'd7 - r_cnt[2:0]];
    assign w_we    = (r_state == S_WDAT) && w_rise && w_done && !ce_n;

    // Memory is never reset so contents survive rst
    always_ff @(posedge clk) begin
        if (w_we) r_mem[r_ptr] <= w_sh_next[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_sck      <= 1'b0;
            r_sck_q    <= 1'b0;
            r_ce_n     <= 1'b1;
            r_start_ok <= 1'b0;
            r_armed    <= 1'b0;
            r_ser      <= 1'b0;
            r_rd       <= 1'b0;
            r_cnt      <= '0;
            r_sh       <= '0;
            r_ptr      <= '0;
            sio_o      <= 4'h0;
            sio_oe     <= 4'h0;
            qpi_mode   <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            r_sck   <= sck;
            r_sck_q <= r_sck;
            r_ce_n  <= ce_n;
            cmd_err <= 1'b0;
            if (ce_n) begin
                // Deselect aborts anything in flight, including a half byte
                r_state    <= S_IDLE;
                sio_oe     <= 4'h0;
                sio_o      <= 4'h0;
                r_start_ok <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (!r_ce_n && r_start_ok) begin
                            r_state <= S_CMD;
                            r_cnt   <= '0;
                        end
                    end
                    S_CMD: begin
                        if (w_rise) begin
                            r_sh  <= w_sh_next;
                            r_cnt <= r_cnt + 8'd1;
                            if (w_done) begin
                                r_cnt   <= '0;
                                // Control-only and bad opcodes park in ERR until deselect
                                r_state <= S_ERR;
                                r_armed <= (w_op == 8'h66);
                                if (w_op_rd || w_op_wr) begin
                                    r_state <= S_ADR;
                                    r_ser   <= (w_op == 8'h03) || (w_op == 8'h02);
                                    r_rd    <= w_op_rd;
                                end
                                if (w_op_bad)    cmd_err  <= 1'b1;
                                if (w_op == 8'h35) qpi_mode <= 1'b1;
                                if (w_op == 8'hF5) qpi_mode <= 1'b0;
                                if (w_op == 8'h99 && r_armed) qpi_mode <= 1'b0;
                            end
                        end
                    end
                    S_ADR: begin
                        if (w_rise) begin
                            r_sh  <= w_sh_next;
                            r_cnt <= r_cnt + 8'd1;
                            if (w_done) begin
                                r_cnt <= '0;
                                r_ptr <= w_sh_next[MEM_ABITS-1:0];
                                if (!r_rd)                     r_state <= S_WDAT;
                                else if (r_ser || RD_WAIT == 0) r_state <= S_RDAT;
                                else                           r_state <= S_WAIT;
                            end
                        end
                    end
                    S_WAIT: begin
                        if (w_rise) begin
                            r_cnt <= r_cnt + 8'd1;
                            if (w_done) begin
                                r_cnt   <= '0;
                                r_state <= S_RDAT;
                            end
                        end
                    end
                    S_RDAT: begin
                        if (w_fall) begin
                            if (r_ser) begin
                                sio_oe <= 4'b0010;
                                sio_o  <= {2'b00, w_rbit, 1'b0};
                            end else begin
                                sio_oe <= 4'hF;
                                sio_o  <= r_cnt[0] ? w_rbyte[3:0] : w_rbyte[7:4];
                            end
                            r_cnt <= r_cnt + 8'd1;
                            if (w_done) begin
                                r_cnt <= '0;
                                r_ptr <= w_ptr_inc;
                            end
                        end
                    end
                    S_WDAT: begin
                        if (w_rise) begin
                            r_sh  <= w_sh_next;
                            r_cnt <= r_cnt + 8'd1;
                            if (w_done) begin
                                r_cnt <= '0;
                                r_ptr <= w_ptr_inc;
                            end
                        end
                    end
                    default: ;  // S_ERR: bus ignored until deselect
                endcase
            end
        end
    end

endmodule

// File: doc/qspi_psram_model_p.md
# qspi_psram_model_p

Parametrised, cycle-accurate simulation model of a quad-SPI PSRAM used in the QSPI memory-controller testbenches. Successor to the fixed-geometry model: memory depth, read dummy cycles and burst-wrap boundary are parameters. It adds serial (1-bit) read/write, QPI mode (commands and address on all four lines), a strict reset-enable/reset sequence and an error pulse for unknown commands. It sits on the bench side of the controller's sck/ce_n/sio pins and is oversampled by the simulation clock.

## Interface
- MEM_ABITS, 16: implemented byte-address bits; memory is 2^MEM_ABITS bytes, and upper address bits alias.
- RD_WAIT, 6: dummy sck cycles between the last address nibble and the first data nibble for 0xEB.
- PAGE_BITS, 10: burst wrap boundary is 2^PAGE_BITS bytes. Must be ≤ MEM_ABITS.

Ports:
- clk  in  1  simulation oversampling clock
- rst  in  1  asynchronous, active-high reset
- sck  in  1  serial clock from controller, idle low
- ce_n  in  1  chip enable, active low
- sio_i  in  4  serial I/O input
- sio_o  out  4  serial I/O output data
- sio_oe  out  4  per-line output enable
- qpi_mode  out  1  1 = QPI mode active
- cmd_err  out  1  one-clk pulse when an unsupported opcode is received

## Operation
- sck and ce_n are registered once in clk. rise_tick = sck & ~sck_q. fall_tick = ~sck & sck_q.
- sio_i is sampled only on rise_tick.
- ce_n low → transaction start. ce_n high at any time → return to IDLE on the next clk and release sio_oe. A write byte with only its high nibble received is discarded.
- FSM states: IDLE, CMD, ADR, WAIT, RDAT, WDAT, ERR.
  - ERR ignores the bus until ce_n is high.
- CMD phase:
  - SPI mode: 8 bits on sio_i[0], MSB first.
  - QPI mode: 2 nibbles on sio_i[3:0], high nibble first.
- Address: always 24 bits, MSB first.
  - SPI-mode opcodes 0x03 and 0x02 take the address on sio_i[0] (24 ticks).
  - 0xEB and 0x38, and all address phases in QPI mode, take 6 nibbles.
- Opcodes:
  - 0x03 serial read: no dummy cycles; data on sio_o[1], MSB first; sio_oe = 4'b0010. Valid in SPI mode only; in QPI mode it is an error.
  - 0x02 serial write: data on sio_i[0], MSB first. SPI mode only.
  - 0xEB quad read: RD_WAIT dummy cycles, then nibbles high-first; sio_oe = 4'hF.
  - 0x38 quad write: nibbles high-first.
  - 0x35 enter QPI: sets qpi_mode.
  - 0xF5 exit QPI: clears qpi_mode.
  - 0x66 reset enable: arms reset. Any other completed opcode disarms it.
  - 0x99 reset: if armed, clears qpi_mode and disarms. Memory contents are retained. Unarmed 0x99 is a no-op.
  - Any other opcode: cmd_err pulses for 1 clk; FSM → ERR.
- Burst address: byte pointer = addr[MEM_ABITS-1:0] and increments after each completed byte. Bits [PAGE_BITS-1:0] wrap to 0 and the upper bits hold. Example with PAGE_BITS=10: 0x3FF → 0x000, and 0x7FF → 0x400.
- Writes commit a byte on the rise_tick completing its last bit/nibble.

## Timing
- Reset values: sio_o=0, sio_oe=0, qpi_mode=0, cmd_err=0, FSM=IDLE, reset armed=0.
- Input sampling: sio_i is captured on the clk edge where rise_tick is high, i.e. 1–2 clk after the physical sck rise.
- Read output:
  - sio_o updates on the clk after each fall_tick in RDAT.
  - The first data nibble/bit appears after the fall_tick following the last dummy rise; for 0x03, after the last address rise.
  - Data stays stable through the next rise.
- sio_oe asserts with the first data update and deasserts on the clk after ce_n rises.
- cmd_err is asserted on the clk after the rise_tick of the 8th command bit.
- The sck high and low phases must each be ≥ 3 clk. Behaviour with shorter phases is undefined.
- rst asserted mid-transaction: all outputs return to their reset values immediately. Memory is unchanged. The model waits for ce_n high before accepting a new command.

## Test plan
- Quad write 0x38, addr 0x000010, data 0xA5,0x3C; then 0xEB from 0x000010 → reads 0xA5,0x3C; exactly RD_WAIT=6 dummy rises precede the first data nibble.
- Serial write 0x02 at 0x000020 with 0x81; serial read 0x03 → 0x81 on sio_o[1]; sio_oe=4'b0010 and sio_o[0] not driven.
- Enter QPI (0x35), quad write 0x38 at 0x0003FF with 0x11,0x22 → bytes land at 0x3FF and 0x000 (wrap); QPI 0xF5 → qpi_mode=0.
- In QPI mode send 0x66 then 0x99 → qpi_mode=0. Send 0x99 alone in QPI → qpi_mode stays 1. Send 0x66,0x05,0x99 → no reset.
- Opcode 0x5A → cmd_err one-clk pulse, sio_oe stays 0, next transaction 0xEB works normally.
- ce_n raised after 1 nibble of a 0x38 write to 0x30 → mem[0x30] unchanged. rst pulsed mid-0xEB read → sio_oe=0 at once, and the next read returns correct data.
